// File: rtl/fir_pkg.sv
// Shared definitions for the FIR frame controller: state encodings,
// default frame geometry and sample width.
package fir_pkg;

    localparam int FRAME_LEN_D = 1024;
    localparam int TAPS_D      = 32;
    localparam int DW_D        = 16;
    localparam int CNT_W       = $clog2(FRAME_LEN_D);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_PAD,
        ST_DONE
    } state_e;

endpackage

// File: rtl/counter.sv
// Up-counter with synchronous clear and hold; clear wins over advance.
module counter #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         keep,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      cnt <= '0;
        else if (clr)  cnt <= '0;
        else if (!keep) cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/fir_frame_ctrl.sv
// Frame sequencer for a streaming FIR datapath: prime taps, stream a frame,
// flush with zeros, and register the datapath result behind a handshake.
module fir_frame_ctrl
    import fir_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_D,
    parameter int TAPS      = TAPS_D,
    parameter int DW        = DW_D
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] fir_in,
    output logic          fir_in_valid,
    output logic          fir_clr,
    input  logic [DW-1:0] fir_out,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_first,
    output logic          out_last,
    output logic          frame_done,
    output logic          busy
);

    localparam int CW = $clog2(FRAME_LEN);

    state_e        state;
    logic [CW-1:0] smp_cnt;
    logic [CW-1:0] out_cnt;
    logic          stall, feeding, xfer, pad_inj, fire, accept;
    logic          go, fill_end, run_end, smp_clr;

    // A held output beat freezes the whole pipeline, including the zero flush.
    assign stall    = out_valid & ~out_ready;
    assign feeding  = (state == ST_FILL) || (state == ST_RUN);
    assign in_ready = feeding & ~stall & ~abort;
    assign xfer     = in_ready & in_valid;
    assign pad_inj  = (state == ST_PAD) && (smp_cnt != CW'(TAPS-1)) && !stall && !abort;
    assign fire     = ((state == ST_RUN) && xfer) || pad_inj;
    assign accept   = out_valid & out_ready;

    assign fir_in_valid = xfer | pad_inj;
    assign fir_in       = xfer ? in_data : '0;

    assign go       = (state == ST_IDLE) && start && !abort;
    assign fir_clr  = rst & (abort | go);
    assign fill_end = (state == ST_FILL) && xfer && (smp_cnt == CW'(TAPS-2));
    assign run_end  = (state == ST_RUN) && xfer && (smp_cnt == CW'(FRAME_LEN-TAPS));
    assign smp_clr  = abort | go | fill_end | run_end;
    assign busy     = (state != ST_IDLE);

    counter #(.W(CW)) u_smp_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (smp_clr),
        .keep (~(xfer | pad_inj)),
        .cnt  (smp_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            out_cnt    <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (abort) begin
                state     <= ST_IDLE;
                out_cnt   <= '0;
                out_valid <= 1'b0;
                out_first <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                if (fire) begin
                    out_data  <= fir_out;
                    out_valid <= 1'b1;
                    out_first <= (out_cnt == '0);
                    out_last  <= (out_cnt == CW'(FRAME_LEN-1));
                    out_cnt   <= out_cnt + 1'b1;
                end else if (accept) begin
                    out_valid <= 1'b0;
                end
                case (state)
                    ST_IDLE: if (start) begin
                        state   <= ST_FILL;
                        out_cnt <= '0;
                    end
                    ST_FILL: if (fill_end) state <= ST_RUN;
                    ST_RUN:  if (run_end)  state <= ST_PAD;
                    ST_PAD:  if (accept && out_last) begin
                        state      <= ST_DONE;
                        frame_done <= 1'b1;
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
